seq_stream_ctrl: RTL and testbench

Frame sequencer for the serial pattern detector.
- Accepts a parallel WIDTH-bit frame and a mode bit through a load/ready handshake.
- Shifts the frame out MSB-first, one bit per prescaled step, with a one-cycle step strobe; the detector uses the strobe as its clock enable.
- Holds the mode (detector btn) constant for the whole frame.
- Samples the detector's z output after every bit and counts detections per frame.

---
 rtl/seq_stream_ctrl.sv | 166 ++++++++++++++++
 tb/tb_seq_stream_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seq_stream_ctrl
//  Purpose  : Frame sequencer for the serial pattern detector. Takes a
//             parallel frame plus a mode bit through a load/ready handshake,
//             shifts the frame out MSB-first on a prescaled step strobe,
//             holds the detector mode for the whole frame and counts the
//             detector's z matches (saturating) for each frame.
//  Options  : SEQ_STREAM_CTRL_ABORT_EN - adds an 'abort' input that cancels
//             a frame in progress without a done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_stream_ctrl #(
  parameter int WIDTH = 8,   // frame length in bits (>=2)
  parameter int DIV   = 4,   // clock cycles per bit step (>=1)
  parameter int HW    = 4    // hit counter width
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  output logic             ready,
  input  logic [WIDTH-1:0] data,
  input  logic             mode,
  output logic             x_out,
  output logic             btn_out,
  output logic             step,
  input  logic             z_in,
`ifdef SEQ_STREAM_CTRL_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [HW-1:0]    hits
);

  // Prescaler needs at least one bit even when DIV==1 (it then never moves).
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(WIDTH);

  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [BW-1:0] BIT_FIRST  = BW'(WIDTH - 1);
  localparam logic [HW-1:0] HITS_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic [PW-1:0]    presc;
  logic             first_step;   // next step is the first of the frame
  logic             accept;
  logic             active;
  logic             tick;
  logic             abort_req;

`ifdef SEQ_STREAM_CTRL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign active = (state == S_SHIFT) || (state == S_FLUSH);
  assign tick   = (presc == PRESC_LAST);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and Moore-style outputs; abort only acts while a frame
  // is shifting or flushing and also masks the step of that cycle.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    step      = 1'b0;
    x_out     = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (load) begin
          accept    = 1'b1;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy  = 1'b1;
        x_out = shreg[WIDTH-1];
        if (abort_req) begin
          state_nxt = S_IDLE;
        end else if (tick) begin
          step = 1'b1;
          if (bit_cnt == '0) begin
            state_nxt = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        busy = 1'b1;
        if (abort_req) begin
          state_nxt = S_IDLE;
        end else if (tick) begin
          step      = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Frame datapath: capture on accept, shift/count on step, sample z except
  // on the first step (that value still belongs to the previous frame).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      presc      <= '0;
      first_step <= 1'b0;
      btn_out    <= 1'b0;
      hits       <= '0;
    end else if (accept) begin
      shreg      <= data;
      btn_out    <= mode;
      bit_cnt    <= BIT_FIRST;
      presc      <= '0;
      first_step <= 1'b1;
      hits       <= '0;
    end else if (active && !abort_req) begin
      if (step) begin
        presc      <= '0;
        shreg      <= shreg << 1;
        first_step <= 1'b0;
        if (bit_cnt != '0) begin
          bit_cnt <= bit_cnt - 1'b1;
        end
        if (!first_step && z_in && (hits != HITS_MAX)) begin
          hits <= hits + 1'b1;
        end
      end else begin
        presc <= presc + 1'b1;
      end
    end else if (abort_req) begin
      presc <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_stream_ctrl
//  Purpose  : Self-checking bench for seq_stream_ctrl. Instance A uses the
//             default parameters, instance B (DIV=1, HW=2) covers the
//             every-cycle step and hit saturation. Expected behaviour comes
//             from a frame-level model: step/done times as multiples of DIV,
//             the bit order of the frame, and a count of sampled z values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_stream_ctrl;
  localparam int W     = 8;
  localparam int DIV_A = 4;
  localparam int DIV_B = 1;
  localparam int Z_DET = 0;
  localparam int Z_RND = 1;
  localparam int Z_ONE = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         sel;
  logic         load_drv;
  logic [W-1:0] data_drv;
  logic         mode_drv;
  logic         z_drv;
`ifdef SEQ_STREAM_CTRL_ABORT_EN
  logic         abort;
`endif

  logic ready_a, x_a, btn_a, step_a, busy_a, done_a;
  logic ready_b, x_b, btn_b, step_b, busy_b, done_b;
  logic [3:0] hits_a;
  logic [1:0] hits_b;
  logic load_a, load_b;
  logic ready_m, x_m, btn_m, step_m, busy_m, done_m;
  logic [3:0] hits_m;

  int checks   = 0;
  int failures = 0;

  assign load_a  = load_drv & ~sel;
  assign load_b  = load_drv & sel;
  assign ready_m = sel ? ready_b : ready_a;
  assign x_m     = sel ? x_b     : x_a;
  assign btn_m   = sel ? btn_b   : btn_a;
  assign step_m  = sel ? step_b  : step_a;
  assign busy_m  = sel ? busy_b  : busy_a;
  assign done_m  = sel ? done_b  : done_a;
  assign hits_m  = sel ? {2'b00, hits_b} : hits_a;

  seq_stream_ctrl #(.WIDTH(W), .DIV(DIV_A), .HW(4)) u_dut_a (
    .clk(clk), .reset(reset), .load(load_a), .ready(ready_a), .data(data_drv),
    .mode(mode_drv), .x_out(x_a), .btn_out(btn_a), .step(step_a), .z_in(z_drv),
`ifdef SEQ_STREAM_CTRL_ABORT_EN
    .abort(abort),
`endif
    .busy(busy_a), .done(done_a), .hits(hits_a)
  );

  seq_stream_ctrl #(.WIDTH(W), .DIV(DIV_B), .HW(2)) u_dut_b (
    .clk(clk), .reset(reset), .load(load_b), .ready(ready_b), .data(data_drv),
    .mode(mode_drv), .x_out(x_b), .btn_out(btn_b), .step(step_b), .z_in(z_drv),
`ifdef SEQ_STREAM_CTRL_ABORT_EN
    .abort(1'b0),
`endif
    .busy(busy_b), .done(done_b), .hits(hits_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] obs_vec();
    return {step_m, x_m, btn_m, busy_m, done_m, ready_m, hits_m};
  endfunction

  // One frame on the selected instance, checked every cycle from acceptance
  // to one cycle past done. hold keeps load high through the frame so the
  // next frame is taken the cycle ready rises. stop_at>0 returns early.
  task automatic run_frame(input logic s, input logic [W-1:0] d, input logic m,
                           input int zsel, input bit hold, input int stop_at);
    int div, hmax, last, cnt, guard;
    logic [5:0] hist, pat;
    logic ste, xe, be, de, re;
    logic [3:0] he;
    logic [9:0] expv;
    div  = s ? DIV_B : DIV_A;
    hmax = s ? 3 : 15;
    last = (W + 1) * div;
    sel  = s;
    guard = 0;
    while (ready_m !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_wait", ready_m, 1);
    if (ready_m !== 1'b1) return;
    load_drv = 1'b1;
    data_drv = d;
    mode_drv = m;
`ifdef SEQ_STREAM_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    @(posedge clk);
    cnt  = 0;
    hist = '0;
    pat  = m ? 6'b110010 : 6'b110110;
    for (int t = 1; t <= last + 2; t++) begin
      @(negedge clk);
      ste  = ((t % div) == 0) && (t <= last);
      xe   = (t <= W * div) ? d[W - 1 - (t - 1) / div] : 1'b0;
      be   = (t <= last);
      de   = (t == last + 1);
      re   = (t >= last + 2);
      he   = 4'((cnt > hmax) ? hmax : cnt);
      expv = {ste, xe, m, be, de, re, he};
      chk($sformatf("cyc_t%0d", t), obs_vec(), expv);
      if (!hold) load_drv = 1'b0;
      data_drv = W'($urandom);
      mode_drv = 1'($urandom);
      case (zsel)
        Z_DET:   z_drv = (hist == pat);
        Z_RND:   z_drv = 1'($urandom_range(0, 1));
        default: z_drv = 1'b1;
      endcase
      if (ste) begin
        if (t / div > 1) cnt += int'(z_drv);
        hist = {hist[4:0], xe};
      end
      if (t == stop_at) begin
        load_drv = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    int dcnt;
    int scnt;
    bit hold;
    reset    = 1'b1;
    sel      = 1'b0;
    load_drv = 1'b0;
    data_drv = '0;
    mode_drv = 1'b0;
    z_drv    = 1'b0;
`ifdef SEQ_STREAM_CTRL_ABORT_EN
    abort    = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_a", obs_vec(), 10'h010);
    sel = 1'b1;
    chk("reset_b", obs_vec(), 10'h010);
    sel = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    // Directed detector frames.
    run_frame(1'b0, 8'b1100_1000, 1'b1, Z_DET, 1'b0, 0);
    chk("hits_basic", hits_m, 1);
    run_frame(1'b0, 8'b1101_1000, 1'b0, Z_DET, 1'b0, 0);
    chk("hits_mode0", hits_m, 1);
    run_frame(1'b0, 8'b1101_1000, 1'b1, Z_DET, 1'b0, 0);
    chk("hits_mode1", hits_m, 0);

    // Load held through a frame, next frame taken as ready rises.
    run_frame(1'b0, 8'hF0, 1'b1, Z_ONE, 1'b1, 0);
    run_frame(1'b0, 8'h3C, 1'b0, Z_DET, 1'b0, 0);

    // Randomized frames on instance A.
    for (int i = 0; i < 20; i++) begin
      hold = ($urandom_range(0, 3) == 0) && (i != 19);
      run_frame(1'b0, W'($urandom), 1'($urandom), $urandom_range(0, 1), hold, 0);
    end

    // Saturation and DIV=1 on instance B.
    run_frame(1'b1, 8'hA5, 1'b0, Z_ONE, 1'b0, 0);
    chk("sat_hits", hits_m, 3);
    for (int i = 0; i < 6; i++) begin
      hold = ($urandom_range(0, 1) == 0) && (i != 5);
      run_frame(1'b1, W'($urandom), 1'($urandom), Z_RND, hold, 0);
    end

    // Asynchronous reset in the middle of a frame.
    run_frame(1'b0, 8'hA5, 1'b1, Z_ONE, 1'b0, 13);
    #1 reset = 1'b1;
    #1 chk("reset_midframe", obs_vec(), 10'h010);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done_m || busy_m) dcnt++;
    end
    chk("no_done_after_reset", dcnt, 0);

`ifdef SEQ_STREAM_CTRL_ABORT_EN
    // Abort on the third step cycle.
    run_frame(1'b0, 8'hFF, 1'b1, Z_ONE, 1'b0, 12);
    abort = 1'b1;
    #1 chk("abort_step_masked", step_m, 0);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", {step_m, x_m, busy_m, done_m, ready_m, hits_m}, {5'b00001, 4'd1});
    dcnt = 0;
    scnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_m) dcnt++;
      if (step_m) scnt++;
    end
    chk("abort_no_done", dcnt, 0);
    chk("abort_no_step", scnt, 0);
    chk("abort_hits_kept", hits_m, 1);
    // load and abort together in IDLE: load wins.
    load_drv = 1'b1;
    abort    = 1'b1;
    data_drv = 8'h81;
    @(posedge clk);
    @(negedge clk);
    load_drv = 1'b0;
    abort    = 1'b0;
    chk("load_beats_abort", {busy_m, ready_m, hits_m}, {2'b10, 4'd0});
    for (int i = 0; i < 100; i++) begin
      if (ready_m) break;
      @(negedge clk);
    end
    chk("abort_frame_end", ready_m, 1);
`else
    scnt = 0;
    chk("idle_no_step", {step_m, busy_m, 30'(scnt)}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
